// File: rtl/keccak_absorb_padder_pkg.sv
// Shared types, constants and rate/domain lookups for the Keccak absorb padder.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package keccak_absorb_padder_pkg;

  localparam int DATA_SIZE         = 64;
  localparam int VALID_BYTES_WIDTH = 4;
  localparam int MAX_RATE_BYTES    = 168;

  localparam int WORD_BYTES = DATA_SIZE / 8;
  localparam int BLOCK_W    = 8 * MAX_RATE_BYTES;
  localparam int IDX_W      = $clog2(MAX_RATE_BYTES / WORD_BYTES);
  localparam int NB_W       = $clog2(MAX_RATE_BYTES + 1);

  localparam logic [7:0] RATE_SHA3_224 = 8'd144;
  localparam logic [7:0] RATE_SHA3_256 = 8'd136;
  localparam logic [7:0] RATE_SHA3_384 = 8'd104;
  localparam logic [7:0] RATE_SHA3_512 = 8'd72;
  localparam logic [7:0] RATE_SHAKE128 = 8'd168;
  localparam logic [7:0] RATE_SHAKE256 = 8'd136;

  localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
  localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;

  typedef enum logic [2:0] {
    MODE_SHA3_224 = 3'd0,
    MODE_SHA3_256 = 3'd1,
    MODE_SHA3_384 = 3'd2,
    MODE_SHA3_512 = 3'd3,
    MODE_SHAKE128 = 3'd4,
    MODE_SHAKE256 = 3'd5
  } keccak_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAD  = 2'd2,
    EMIT = 2'd3
  } state_t;

  // Reserved encodings 6 and 7 fall into the default arm and act as SHA3-256.
  function automatic logic [7:0] rate_bytes(input logic [2:0] mode);
    case (keccak_mode_t'(mode))
      MODE_SHA3_224: return RATE_SHA3_224;
      MODE_SHA3_384: return RATE_SHA3_384;
      MODE_SHA3_512: return RATE_SHA3_512;
      MODE_SHAKE128: return RATE_SHAKE128;
      MODE_SHAKE256: return RATE_SHAKE256;
      default:       return RATE_SHA3_256;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] rate_words(input logic [2:0] mode);
    return IDX_W'(rate_bytes(mode) / 8'(WORD_BYTES));
  endfunction

  function automatic logic [7:0] domain_byte(input logic [2:0] mode);
    if (mode == MODE_SHAKE128 || mode == MODE_SHAKE256) return DOMAIN_SHAKE;
    return DOMAIN_SHA3;
  endfunction

endpackage

// File: rtl/keccak_absorb_padder_if.sv
// Bundles the message word stream (in) and the rate-block handshake (out).
// Latency: n/a (wires only).
// Backpressure: t_ready_o throttles the word stream, block_ready_i stalls block output.
// Modports: master = the padder (stream sink, block source);
//           slave  = its environment (stream source, block sink).
interface keccak_absorb_padder_if;
  import keccak_absorb_padder_pkg::*;

  logic                         start_i;
  logic [2:0]                   keccak_mode_i;
  logic [DATA_SIZE-1:0]         t_data_i;
  logic                         t_valid_i;
  logic                         t_last_i;
  logic [VALID_BYTES_WIDTH-1:0] t_valid_bytes;
  logic                         t_ready_o;
  logic [BLOCK_W-1:0]           block_o;
  logic                         block_valid_o;
  logic                         block_last_o;
  logic                         block_ready_i;

  modport master (
    input  start_i, keccak_mode_i, t_data_i, t_valid_i, t_last_i, t_valid_bytes,
    input  block_ready_i,
    output t_ready_o, block_o, block_valid_o, block_last_o
  );

  modport slave (
    output start_i, keccak_mode_i, t_data_i, t_valid_i, t_last_i, t_valid_bytes,
    output block_ready_i,
    input  t_ready_o, block_o, block_valid_o, block_last_o
  );

endinterface

// File: rtl/keccak_absorb_padder.sv
// Packs byte-masked message words into rate blocks and applies domain + pad10*1 padding.
// Latency: block_valid_o rises the cycle after the word that completes a block is accepted.
// Backpressure: t_ready_o is low outside FILL; a block is held stable until block_ready_i.
// Ports: clk, rst (async active-low), bus (master modport: word stream in, block out).
module keccak_absorb_padder
  import keccak_absorb_padder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  keccak_absorb_padder_if.master bus
);

  state_t             state_q, state_d;
  logic [2:0]         mode_q, mode_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               pad_pend_q, pad_pend_d;  // message ended exactly on a rate boundary

  logic [7:0]           rate;
  logic [IDX_W-1:0]     rwords;
  logic [7:0]           domain;
  logic [DATA_SIZE-1:0] word_masked;
  logic [NB_W-1:0]      n_bytes;

  assign rate   = rate_bytes(mode_q);
  assign rwords = rate_words(mode_q);
  assign domain = domain_byte(mode_q);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    word_idx_d  = word_idx_q;
    buf_d       = buf_q;
    valid_d     = valid_q;
    last_d      = last_q;
    pad_pend_d  = pad_pend_q;
    word_masked = '0;
    n_bytes     = '0;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          mode_d     = bus.keccak_mode_i;
          buf_d      = '0;
          word_idx_d = '0;
          pad_pend_d = 1'b0;
          state_d    = FILL;
        end
      end

      FILL: begin
        if (bus.t_valid_i) begin
          // Lanes beyond the valid count are zeroed so stale upper bytes never leak into the block.
          for (int b = 0; b < WORD_BYTES; b++) begin
            word_masked[b*8 +: 8] = (b < int'(bus.t_valid_bytes)) ? bus.t_data_i[b*8 +: 8] : 8'h00;
          end
          buf_d[int'(word_idx_q)*DATA_SIZE +: DATA_SIZE] = word_masked;

          if (!bus.t_last_i) begin
            if (word_idx_q == rwords - 1'b1) begin
              word_idx_d = '0;
              last_d     = 1'b0;
              valid_d    = 1'b1;
              state_d    = EMIT;
            end else begin
              word_idx_d = word_idx_q + 1'b1;
            end
          end else begin
            n_bytes    = NB_W'(word_idx_q) * NB_W'(WORD_BYTES) + NB_W'(bus.t_valid_bytes);
            word_idx_d = '0;
            valid_d    = 1'b1;
            state_d    = EMIT;
            if (n_bytes < rate) begin
              // XOR rather than OR-assign: when n == rate-1 both markers share a byte.
              buf_d[int'(n_bytes)*8 +: 8]     = buf_d[int'(n_bytes)*8 +: 8] ^ domain;
              buf_d[(int'(rate)-1)*8 +: 8]    = buf_d[(int'(rate)-1)*8 +: 8] ^ 8'h80;
              last_d = 1'b1;
            end else begin
              // Full block of data; padding goes into a separate trailing block.
              last_d     = 1'b0;
              pad_pend_d = 1'b1;
            end
          end
        end
      end

      PAD: begin
        buf_d                        = '0;
        buf_d[7:0]                   = domain;
        buf_d[(int'(rate)-1)*8 +: 8] = buf_d[(int'(rate)-1)*8 +: 8] ^ 8'h80;
        pad_pend_d                   = 1'b0;
        last_d                       = 1'b1;
        valid_d                      = 1'b1;
        state_d                      = EMIT;
      end

      EMIT: begin
        if (bus.block_ready_i) begin
          buf_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q)          state_d = IDLE;
          else if (pad_pend_q) state_d = PAD;
          else                 state_d = FILL;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      word_idx_q <= '0;
      buf_q      <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      pad_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      word_idx_q <= word_idx_d;
      buf_q      <= buf_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      pad_pend_q <= pad_pend_d;
    end
  end

  assign bus.t_ready_o     = (state_q == FILL);
  assign bus.block_o       = buf_q;
  assign bus.block_valid_o = valid_q;
  assign bus.block_last_o  = last_q;

endmodule
